// File: rtl/dmem_access_ctrl_if.sv
// Bundle of CPU, loader and data_memory signals around dmem_access_ctrl.
// Handshake: cpu_req is a valid that must hold cpu_* stable until a cycle
// with cpu_ready=1 (the access completes in that cycle); ldr_req likewise
// holds ldr_* until the cycle with ldr_ack=1.
interface dmem_access_ctrl_if #(
  parameter int IDX_W = 10
);
  logic              cpu_req;
  logic              cpu_we;
  logic [2:0]        cpu_funct3;
  logic [63:0]       cpu_addr;
  logic [63:0]       cpu_wdata;
  logic [63:0]       cpu_rdata;
  logic              cpu_ready;
  logic              cpu_misalign;
  logic              ldr_req;
  logic [IDX_W-1:0]  ldr_idx;
  logic [63:0]       ldr_wdata;
  logic              ldr_ack;
  logic              mem_read;
  logic              mem_write;
  logic [63:0]       mem_addr;
  logic [63:0]       mem_wdata;
  logic [63:0]       mem_rdata;
  logic              dbg_state;

  // Controller side
  modport slave (
    input  cpu_req, cpu_we, cpu_funct3, cpu_addr, cpu_wdata,
    output cpu_rdata, cpu_ready, cpu_misalign,
    input  ldr_req, ldr_idx, ldr_wdata,
    output ldr_ack,
    output mem_read, mem_write, mem_addr, mem_wdata,
    input  mem_rdata,
    output dbg_state
  );

  // Core / loader / memory side
  modport master (
    output cpu_req, cpu_we, cpu_funct3, cpu_addr, cpu_wdata,
    input  cpu_rdata, cpu_ready, cpu_misalign,
    output ldr_req, ldr_idx, ldr_wdata,
    input  ldr_ack,
    input  mem_read, mem_write, mem_addr, mem_wdata,
    output mem_rdata,
    input  dbg_state
  );
endinterface

// File: rtl/dmem_access_ctrl.sv
// Data memory access sequencer: converts MEM-stage loads/stores into
// doubleword memory operations, does sub-doubleword stores as a 2-cycle
// read-modify-write, and shares the memory with a boot loader write port.
module dmem_access_ctrl #(
  parameter int IDX_W = 10
) (
  input  logic              clk,
  input  logic              rst,
  dmem_access_ctrl_if.slave bus
);

  localparam logic [0:0] S_IDLE   = 1'b0;
  localparam logic [0:0] S_RMW_WR = 1'b1;

  logic [0:0]       state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [63:0]      merged_q, merged_d;

  logic [1:0]       sz_code;
  logic [2:0]       off;
  logic [IDX_W-1:0] cpu_idx;
  logic             misalign;
  logic [63:0]      lane;
  logic [63:0]      load_val;
  logic [7:0]       bmask;
  logic [7:0]       bmask_sh;
  logic [63:0]      wmask;
  logic [63:0]      merge_val;

  // Decode access size, lane, alignment, load extension and store merge
  always_comb begin
    sz_code  = bus.cpu_funct3[1:0];
    off      = bus.cpu_addr[2:0];
    cpu_idx  = bus.cpu_addr[IDX_W+2:3];
    misalign = 1'b0;
    bmask    = 8'hFF;
    load_val = 64'd0;
    wmask    = 64'd0;
    lane     = bus.mem_rdata >> {off, 3'b000};
    case (sz_code)
      2'b00: begin
        bmask    = 8'h01;
        load_val = {{56{lane[7] & ~bus.cpu_funct3[2]}}, lane[7:0]};
      end
      2'b01: begin
        misalign = off[0];
        bmask    = 8'h03;
        load_val = {{48{lane[15] & ~bus.cpu_funct3[2]}}, lane[15:0]};
      end
      2'b10: begin
        misalign = (off[1:0] != 2'b00);
        bmask    = 8'h0F;
        load_val = {{32{lane[31] & ~bus.cpu_funct3[2]}}, lane[31:0]};
      end
      default: begin
        misalign = (off != 3'b000);
        bmask    = 8'hFF;
        load_val = bus.mem_rdata;
      end
    endcase
    bmask_sh = bmask << off;
    for (int i = 0; i < 8; i++) begin
      wmask[8*i +: 8] = {8{bmask_sh[i]}};
    end
    merge_val = (bus.mem_rdata & ~wmask) | ((bus.cpu_wdata << {off, 3'b000}) & wmask);
  end

  // Next-state and output logic; everything is forced to 0 while in reset
  always_comb begin
    state_d          = state_q;
    idx_d            = idx_q;
    merged_d         = merged_q;
    bus.cpu_rdata    = 64'd0;
    bus.cpu_ready    = 1'b0;
    bus.cpu_misalign = 1'b0;
    bus.ldr_ack      = 1'b0;
    bus.mem_read     = 1'b0;
    bus.mem_write    = 1'b0;
    bus.mem_addr     = 64'd0;
    bus.mem_wdata    = 64'd0;
    bus.dbg_state    = state_q;
    if (state_q == S_RMW_WR) begin
      // Commit the merged doubleword; the loader waits for IDLE
      bus.mem_write = 1'b1;
      bus.mem_addr  = {{(64-IDX_W){1'b0}}, idx_q};
      bus.mem_wdata = merged_q;
      bus.cpu_ready = 1'b1;
      state_d       = S_IDLE;
    end else if (bus.ldr_req) begin
      bus.mem_write = 1'b1;
      bus.mem_addr  = {{(64-IDX_W){1'b0}}, bus.ldr_idx};
      bus.mem_wdata = bus.ldr_wdata;
      bus.ldr_ack   = 1'b1;
    end else if (bus.cpu_req) begin
      if (misalign) begin
        bus.cpu_misalign = 1'b1;
        bus.cpu_ready    = 1'b1;
      end else if (!bus.cpu_we) begin
        bus.mem_read  = 1'b1;
        bus.mem_addr  = {{(64-IDX_W){1'b0}}, cpu_idx};
        bus.cpu_rdata = load_val;
        bus.cpu_ready = 1'b1;
      end else if (sz_code == 2'b11) begin
        bus.mem_write = 1'b1;
        bus.mem_addr  = {{(64-IDX_W){1'b0}}, cpu_idx};
        bus.mem_wdata = bus.cpu_wdata;
        bus.cpu_ready = 1'b1;
      end else begin
        // Read phase of the partial store: capture index and merged word
        bus.mem_read = 1'b1;
        bus.mem_addr = {{(64-IDX_W){1'b0}}, cpu_idx};
        idx_d        = cpu_idx;
        merged_d     = merge_val;
        state_d      = S_RMW_WR;
      end
    end
    if (rst) begin
      bus.cpu_rdata    = 64'd0;
      bus.cpu_ready    = 1'b0;
      bus.cpu_misalign = 1'b0;
      bus.ldr_ack      = 1'b0;
      bus.mem_read     = 1'b0;
      bus.mem_write    = 1'b0;
      bus.mem_addr     = 64'd0;
      bus.mem_wdata    = 64'd0;
      bus.dbg_state    = 1'b0;
    end
  end

  // State and RMW capture registers; async reset drops any pending write
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      idx_q    <= '0;
      merged_q <= 64'd0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      merged_q <= merged_d;
    end
  end

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Testbench for dmem_access_ctrl: directed scenarios plus random accesses
// against a byte-addressed reference memory.
module tb_dmem_access_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  dmem_access_ctrl_if #(.IDX_W(10)) bus ();

  dmem_access_ctrl #(.IDX_W(10)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  // Data memory: combinational read, write at posedge
  logic [63:0] mem     [1024] = '{default: 64'd0};
  logic [63:0] ref_mem [1024] = '{default: 64'd0};

  always_comb bus.mem_rdata = mem[bus.mem_addr[9:0]];

  always @(posedge clk) begin
    if (bus.mem_write) mem[bus.mem_addr[9:0]] <= bus.mem_wdata;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference model: memory viewed as bytes
  function automatic int acc_size(input logic [2:0] f3);
    return 1 << f3[1:0];
  endfunction

  function automatic logic ref_misalign(input logic [2:0] f3, input logic [63:0] a);
    return (a[2:0] & 3'(acc_size(f3) - 1)) != 3'd0;
  endfunction

  function automatic logic [7:0] ref_byte(input logic [63:0] a);
    logic [63:0] w;
    w = ref_mem[a[12:3]];
    return w[a[2:0]*8 +: 8];
  endfunction

  function automatic logic [63:0] ref_load(input logic [2:0] f3, input logic [63:0] a);
    logic [63:0] v;
    int sz;
    sz = acc_size(f3);
    v  = 64'd0;
    for (int i = 0; i < sz; i++) v[8*i +: 8] = ref_byte(a + 64'(i));
    if (!f3[2] && sz < 8 && v[8*sz-1]) begin
      for (int j = 8*sz; j < 64; j++) v[j] = 1'b1;
    end
    return v;
  endfunction

  task automatic ref_store(input logic [2:0] f3, input logic [63:0] a, input logic [63:0] wd);
    logic [63:0] b;
    logic [63:0] w;
    for (int i = 0; i < acc_size(f3); i++) begin
      b = a + 64'(i);
      w = ref_mem[b[12:3]];
      w[b[2:0]*8 +: 8] = wd[8*i +: 8];
      ref_mem[b[12:3]] = w;
    end
  endtask

  // Driver: one loader write in an idle cycle
  task automatic ldr_write(input logic [9:0] idx, input logic [63:0] data);
    bus.ldr_req   = 1'b1;
    bus.ldr_idx   = idx;
    bus.ldr_wdata = data;
    @(negedge clk);
    chk("ldr_ack", 64'(bus.ldr_ack), 64'd1);
    chk("ldr_addr", bus.mem_addr, 64'(idx));
    chk("ldr_cpu_ready", 64'(bus.cpu_ready), 64'd0);
    @(posedge clk); #1;
    bus.ldr_req = 1'b0;
    ref_mem[idx] = data;
  endtask

  // Driver: one CPU access, checked cycle by cycle against the model
  task automatic cpu_access(input logic we, input logic [2:0] f3, input logic [63:0] a,
                            input logic [63:0] wd, output logic [63:0] rdata_obs);
    logic mis, rmw;
    logic [63:0] exp_rd;
    mis    = ref_misalign(f3, a);
    rmw    = we && !mis && acc_size(f3) != 8;
    exp_rd = (we || mis) ? 64'd0 : ref_load(f3, a);
    bus.cpu_req    = 1'b1;
    bus.cpu_we     = we;
    bus.cpu_funct3 = f3;
    bus.cpu_addr   = a;
    bus.cpu_wdata  = wd;
    @(negedge clk);
    rdata_obs = bus.cpu_rdata;
    chk("ready_c1", 64'(bus.cpu_ready), 64'(!rmw));
    chk("misalign", 64'(bus.cpu_misalign), 64'(mis));
    chk("mem_read_c1", 64'(bus.mem_read), 64'(!mis && (!we || rmw)));
    chk("mem_write_c1", 64'(bus.mem_write), 64'(!mis && we && !rmw));
    chk("rdata", bus.cpu_rdata, exp_rd);
    if (!mis) chk("mem_addr_c1", bus.mem_addr, 64'(a[12:3]));
    if (rmw) begin
      @(posedge clk); #1;
      // The write phase must ignore anything on the CPU side now
      bus.cpu_addr = {$urandom, $urandom};
      bus.cpu_req  = 1'($urandom_range(0, 1));
      @(negedge clk);
      chk("ready_c2", 64'(bus.cpu_ready), 64'd1);
      chk("mem_write_c2", 64'(bus.mem_write), 64'd1);
      chk("mem_addr_c2", bus.mem_addr, 64'(a[12:3]));
      chk("rdata_c2", bus.cpu_rdata, 64'd0);
    end
    if (we && !mis) ref_store(f3, a, wd);
    @(posedge clk); #1;
    bus.cpu_req = 1'b0;
    chk("mem_word", mem[a[12:3]], ref_mem[a[12:3]]);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_ready"}, 64'(bus.cpu_ready), 64'd0);
    chk({tag, "_mis"}, 64'(bus.cpu_misalign), 64'd0);
    chk({tag, "_rdata"}, bus.cpu_rdata, 64'd0);
    chk({tag, "_ack"}, 64'(bus.ldr_ack), 64'd0);
    chk({tag, "_mrd"}, 64'(bus.mem_read), 64'd0);
    chk({tag, "_mwr"}, 64'(bus.mem_write), 64'd0);
    chk({tag, "_maddr"}, bus.mem_addr, 64'd0);
    chk({tag, "_mwdata"}, bus.mem_wdata, 64'd0);
  endtask

  initial begin
    logic [63:0] rd;
    logic [63:0] a;
    logic [2:0]  f3;
    logic        we;
    int          bad;
    bus.cpu_req    = 1'b1;
    bus.cpu_we     = 1'b0;
    bus.cpu_funct3 = 3'b011;
    bus.cpu_addr   = 64'h28;
    bus.cpu_wdata  = 64'd0;
    bus.ldr_req    = 1'b1;
    bus.ldr_idx    = 10'd3;
    bus.ldr_wdata  = 64'hDEAD;

    // Reset: outputs held at 0 even with requests asserted
    repeat (2) @(posedge clk);
    #1;
    chk_all_zero("reset");
    chk("reset_state", 64'(bus.dbg_state), 64'd0);
    bus.cpu_req = 1'b0;
    bus.ldr_req = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    chk_all_zero("idle");

    // Loads from a known doubleword
    ldr_write(10'd5, 64'h8899AABB_CCDDEEFF);
    cpu_access(1'b0, 3'b011, 64'h28, 64'd0, rd);
    chk("ld_0x28", rd, 64'h8899AABBCCDDEEFF);
    cpu_access(1'b0, 3'b010, 64'h2C, 64'd0, rd);
    chk("lw_0x2c", rd, 64'hFFFFFFFF8899AABB);
    cpu_access(1'b0, 3'b100, 64'h2F, 64'd0, rd);
    chk("lbu_0x2f", rd, 64'h0000000000000088);
    cpu_access(1'b0, 3'b111, 64'h28, 64'd0, rd);
    chk("ld111_0x28", rd, 64'h8899AABBCCDDEEFF);

    // Byte store as RMW, then load back in the very next cycle
    ldr_write(10'd2, 64'd0);
    cpu_access(1'b1, 3'b000, 64'h13, 64'hA5, rd);
    chk("sb_word2", mem[2], 64'h00000000_A5000000);
    cpu_access(1'b0, 3'b000, 64'h13, 64'd0, rd);
    chk("lb_0x13", rd, 64'hFFFFFFFFFFFFFFA5);

    // Doubleword store
    cpu_access(1'b1, 3'b011, 64'h10, 64'h1122334455667788, rd);
    chk("sd_word2", mem[2], 64'h1122334455667788);

    // Misaligned accesses: no memory effect
    cpu_access(1'b0, 3'b001, 64'h11, 64'd0, rd);
    cpu_access(1'b1, 3'b010, 64'h16, 64'hFFFF_FFFF, rd);
    chk("sw_mis_word2", mem[2], 64'h1122334455667788);

    // Loader and CPU load in the same idle cycle
    bus.ldr_req = 1'b1; bus.ldr_idx = 10'd7; bus.ldr_wdata = 64'hCAFEF00D_12345678;
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_funct3 = 3'b011; bus.cpu_addr = 64'h38;
    @(negedge clk);
    chk("arb_ack", 64'(bus.ldr_ack), 64'd1);
    chk("arb_ready", 64'(bus.cpu_ready), 64'd0);
    chk("arb_rdata", bus.cpu_rdata, 64'd0);
    chk("arb_mrd", 64'(bus.mem_read), 64'd0);
    @(posedge clk); #1;
    bus.ldr_req = 1'b0;
    ref_mem[7] = 64'hCAFEF00D_12345678;
    @(negedge clk);
    chk("arb_ready2", 64'(bus.cpu_ready), 64'd1);
    chk("arb_rdata2", bus.cpu_rdata, 64'hCAFEF00D_12345678);
    @(posedge clk); #1;
    bus.cpu_req = 1'b0;

    // Loader request arriving during the RMW write phase waits one cycle
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b1; bus.cpu_funct3 = 3'b000;
    bus.cpu_addr = 64'h21; bus.cpu_wdata = 64'h5A;
    @(negedge clk);
    chk("lrmw_ready1", 64'(bus.cpu_ready), 64'd0);
    @(posedge clk); #1;
    bus.ldr_req = 1'b1; bus.ldr_idx = 10'd9; bus.ldr_wdata = 64'h0F0F0F0F_F0F0F0F0;
    @(negedge clk);
    chk("lrmw_ack_deferred", 64'(bus.ldr_ack), 64'd0);
    chk("lrmw_ready2", 64'(bus.cpu_ready), 64'd1);
    chk("lrmw_addr2", bus.mem_addr, 64'd4);
    ref_store(3'b000, 64'h21, 64'h5A);
    @(posedge clk); #1;
    bus.cpu_req = 1'b0;
    @(negedge clk);
    chk("lrmw_ack", 64'(bus.ldr_ack), 64'd1);
    chk("lrmw_ldr_addr", bus.mem_addr, 64'd9);
    @(posedge clk); #1;
    bus.ldr_req = 1'b0;
    ref_mem[9] = 64'h0F0F0F0F_F0F0F0F0;
    chk("lrmw_word4", mem[4], ref_mem[4]);
    chk("lrmw_word9", mem[9], 64'h0F0F0F0F_F0F0F0F0);

    // Reset while the RMW write is pending drops the write
    ldr_write(10'd1, 64'h01234567_89ABCDEF);
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b1; bus.cpu_funct3 = 3'b001;
    bus.cpu_addr = 64'h08; bus.cpu_wdata = 64'hBEEF;
    @(negedge clk);
    chk("rst_rmw_ready1", 64'(bus.cpu_ready), 64'd0);
    @(posedge clk); #1;
    chk("rst_rmw_state", 64'(bus.dbg_state), 64'd1);
    rst = 1'b1;
    #2;
    chk_all_zero("rst_rmw");
    chk("rst_rmw_state0", 64'(bus.dbg_state), 64'd0);
    @(posedge clk); #1;
    bus.cpu_req = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_rmw_word1", mem[1], 64'h01234567_89ABCDEF);
    chk("rst_rmw_idle_mwr", 64'(bus.mem_write), 64'd0);
    @(posedge clk); #1;

    // Random traffic over a small set of words so accesses collide
    for (int i = 0; i < 16; i++) ldr_write(10'(i), {$urandom, $urandom});
    for (int n = 0; n < 300; n++) begin
      we = 1'($urandom_range(0, 1));
      f3 = we ? 3'($urandom_range(0, 3)) : 3'($urandom_range(0, 7));
      a  = {$urandom, $urandom};
      a[12:3] = 10'($urandom_range(0, 15));
      if ($urandom_range(0, 3) != 0) a[2:0] = a[2:0] & ~3'(acc_size(f3) - 1);
      cpu_access(we, f3, a, {$urandom, $urandom}, rd);
      if ($urandom_range(0, 9) == 0) ldr_write(10'($urandom_range(0, 15)), {$urandom, $urandom});
    end

    bad = 0;
    for (int i = 0; i < 1024; i++) if (mem[i] !== ref_mem[i]) bad++;
    chk("mem_final", 64'(bad), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
